// File: rtl/udp_speed_pkg.sv
// Shared constants for the tri-speed rate-enable generator: normalised speed
// codes, FSM state encodings and the speed-normalise helper.
package udp_speed_pkg;

   localparam logic [1:0] SPD_1000 = 2'b10;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_10   = 2'b00;

   localparam logic [1:0] StRun      = 2'd0;
   localparam logic [1:0] StDebounce = 2'd1;
   localparam logic [1:0] StDrain    = 2'd2;
   localparam logic [1:0] StSwitch   = 2'd3;

   // Bit 1 set means gigabit regardless of bit 0, so 2'b11 folds onto 2'b10.
   function automatic logic [1:0] norm_speed(input logic [1:0] i_code);
      if (i_code[1]) begin
         return SPD_1000;
      end else if (i_code[0]) begin
         return SPD_100;
      end else begin
         return SPD_10;
      end
   endfunction

endpackage

// File: rtl/udp_sync_bits.sv
// Generic multi-flop synchroniser with asynchronous active-low reset.
module udp_sync_bits #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sync [STAGES];

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= RESET_VAL;
         end
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/udp_speed_ce_gen.sv
// Tri-speed rate-enable generator: turns the PHY speed code into a clock
// enable on clk_125_in, debouncing the code and switching rate only once the
// datapath has drained (or a drain timeout forces it).
module udp_speed_ce_gen
   import udp_speed_pkg::*;
#(
   parameter int unsigned CLK_DIV_100M    = 10,
   parameter int unsigned CLK_DIV_10M     = 100,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned DRAIN_TIMEOUT   = 65535,
   parameter logic [1:0]  RESET_SPEED     = 2'b10
) (
   input  logic       clk_125_in,
   input  logic       reset_n,
   input  logic [1:0] tri_speed,
   input  logic       path_idle,
   output logic       udp_ce,
   output logic [1:0] speed_cur,
   output logic       speed_chg_busy,
   output logic       speed_chg_done,
   output logic       drain_timeout
);

   localparam int unsigned DivW = $clog2(CLK_DIV_10M) + 1;
   localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned DrnW = $clog2(DRAIN_TIMEOUT) + 1;

   localparam logic [DivW-1:0] Div100Max = DivW'(CLK_DIV_100M - 1);
   localparam logic [DivW-1:0] Div10Max  = DivW'(CLK_DIV_10M - 1);
   localparam logic [DebW-1:0] DebLoad   = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DrnW-1:0] DrnLast   = DrnW'(DRAIN_TIMEOUT - 1);

   logic [1:0]      w_spd_raw;
   logic [1:0]      w_spd;

   logic [1:0]      r_state,  w_state_nxt;
   logic [1:0]      r_speed,  w_speed_nxt;
   logic [1:0]      r_target, w_target_nxt;
   logic [DebW-1:0] r_deb,    w_deb_nxt;
   logic [DrnW-1:0] r_drn,    w_drn_nxt;
   logic [DivW-1:0] r_div,    w_div_nxt;
   logic [DivW-1:0] w_div_max;
   logic            r_ce,     w_ce_nxt;
   logic            r_busy,   w_busy_nxt;
   logic            r_done,   w_done_nxt;
   logic            r_tmo,    w_tmo_nxt;

   udp_sync_bits #(
      .WIDTH     (2),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RESET_SPEED)
   ) u_sync (
      .i_clk   (clk_125_in),
      .i_rst_n (reset_n),
      .i_d     (tri_speed),
      .o_q     (w_spd_raw)
   );

   assign w_spd = norm_speed(w_spd_raw);

   // Speed-change FSM: debounce the synced code, wait for drain, then switch.
   always_comb begin
      w_state_nxt  = r_state;
      w_speed_nxt  = r_speed;
      w_target_nxt = r_target;
      w_deb_nxt    = r_deb;
      w_drn_nxt    = r_drn;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_tmo_nxt    = 1'b0;
      case (r_state)
         StRun: begin
            if (w_spd != r_speed) begin
               w_target_nxt = w_spd;
               w_deb_nxt    = DebLoad;
               w_state_nxt  = StDebounce;
            end
         end
         StDebounce: begin
            if (w_spd == r_speed) begin
               // Glitch: code returned to the applied speed before it settled.
               w_state_nxt = StRun;
            end else if (w_spd != r_target) begin
               w_target_nxt = w_spd;
               w_deb_nxt    = DebLoad;
            end else if (r_deb == '0) begin
               w_state_nxt = StDrain;
               w_busy_nxt  = 1'b1;
               w_drn_nxt   = '0;
            end else begin
               w_deb_nxt = r_deb - 1'b1;
            end
         end
         StDrain: begin
            // Idle has priority so a simultaneous timeout is not reported.
            if (path_idle) begin
               w_state_nxt = StSwitch;
            end else if (r_drn == DrnLast) begin
               w_state_nxt = StSwitch;
               w_tmo_nxt   = 1'b1;
            end else begin
               w_drn_nxt = r_drn + 1'b1;
            end
         end
         StSwitch: begin
            w_speed_nxt = r_target;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = StRun;
         end
         default: begin
            w_state_nxt = StRun;
         end
      endcase
   end

   // Rate divider and registered enable; enable is held low for the switch cycle.
   always_comb begin
      w_div_max = (r_speed == SPD_100) ? Div100Max : Div10Max;
      w_div_nxt = r_div;
      w_ce_nxt  = 1'b0;
      if (r_state == StSwitch) begin
         w_div_nxt = '0;
         w_ce_nxt  = (r_target == SPD_1000);
      end else if (w_state_nxt == StSwitch) begin
         w_div_nxt = r_div;
         w_ce_nxt  = 1'b0;
      end else if (r_speed == SPD_1000) begin
         w_div_nxt = '0;
         w_ce_nxt  = 1'b1;
      end else begin
         w_div_nxt = (r_div >= w_div_max) ? '0 : r_div + 1'b1;
         w_ce_nxt  = (w_div_nxt == w_div_max);
      end
   end

   // State, counters and output flags.
   always_ff @(posedge clk_125_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= StRun;
         r_speed  <= RESET_SPEED;
         r_target <= RESET_SPEED;
         r_deb    <= '0;
         r_drn    <= '0;
         r_div    <= '0;
         r_ce     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_tmo    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_speed  <= w_speed_nxt;
         r_target <= w_target_nxt;
         r_deb    <= w_deb_nxt;
         r_drn    <= w_drn_nxt;
         r_div    <= w_div_nxt;
         r_ce     <= w_ce_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_tmo    <= w_tmo_nxt;
      end
   end

   assign udp_ce         = r_ce;
   assign speed_cur      = r_speed;
   assign speed_chg_busy = r_busy;
   assign speed_chg_done = r_done;
   assign drain_timeout  = r_tmo;

endmodule

// File: tb/tb_udp_speed_ce_gen.sv
// Bench for udp_speed_ce_gen: table-driven scenarios, hand-written corner
// sequences and random stimulus, all checked every cycle against a
// behavioural model of the speed-change rules.
module tb_udp_speed_ce_gen;

   localparam int unsigned DIV100 = 10;
   localparam int unsigned DIV10  = 100;
   localparam int unsigned SYNC   = 2;
   localparam int unsigned DEB    = 16;
   localparam int unsigned TMO    = 300;
   localparam logic [1:0]  RSPD   = 2'b10;

   logic       clk;
   logic       rst_n;
   logic [1:0] ts;
   logic       idle;
   logic       udp_ce;
   logic [1:0] speed_cur;
   logic       busy;
   logic       done;
   logic       tmo;

   int n_tests = 0;
   int n_fail  = 0;

   udp_speed_ce_gen #(
      .CLK_DIV_100M    (DIV100),
      .CLK_DIV_10M     (DIV10),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .DRAIN_TIMEOUT   (TMO),
      .RESET_SPEED     (RSPD)
   ) dut (
      .clk_125_in     (clk),
      .reset_n        (rst_n),
      .tri_speed      (ts),
      .path_idle      (idle),
      .udp_ce         (udp_ce),
      .speed_cur      (speed_cur),
      .speed_chg_busy (busy),
      .speed_chg_done (done),
      .drain_timeout  (tmo)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic check(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         if (n_fail <= 40) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
         end
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [1:0] m_q[$];
   logic [1:0] m_cur, m_cand;
   int         m_stable, m_drain_age, m_age;
   bit         m_draining, m_switch;
   bit         m_ce, m_busy, m_done, m_tmo;
   bit         m_en = 1'b0;

   function automatic logic [1:0] ref_norm(input logic [1:0] s);
      return (s >= 2'd2) ? 2'b10 : s;
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < int'(SYNC); i++) m_q.push_back(RSPD);
      m_cur = RSPD; m_cand = RSPD;
      m_stable = 0; m_drain_age = 0; m_age = 0;
      m_draining = 0; m_switch = 0;
      m_ce = 0; m_busy = 0; m_done = 0; m_tmo = 0;
   endtask

   task automatic model_step();
      logic [1:0] spd;
      bit sw_now, go_sw;
      int div;
      spd = ref_norm(m_q[0]);
      m_q.push_back(ts);
      void'(m_q.pop_front());
      sw_now = m_switch;
      go_sw  = 0;
      m_done = 0;
      m_tmo  = 0;
      if (sw_now) begin
         m_cur = m_cand; m_switch = 0; m_done = 1; m_busy = 0;
      end else if (m_draining) begin
         if (idle || (m_drain_age + 1 == int'(TMO))) begin
            go_sw = 1; m_tmo = !idle; m_draining = 0; m_switch = 1;
         end else begin
            m_drain_age++;
         end
      end else begin
         // Count consecutive cycles the synced code has shown the same new value.
         if (spd == m_cur) m_stable = 0;
         else if (m_stable > 0 && spd == m_cand) m_stable++;
         else begin m_cand = spd; m_stable = 1; end
         if (m_stable == int'(DEB) + 1) begin
            m_draining = 1; m_drain_age = 0; m_busy = 1; m_stable = 0;
         end
      end
      div = (m_cur == 2'b01) ? int'(DIV100) : int'(DIV10);
      if (sw_now) begin
         m_age = 0;
         m_ce  = (m_cur == 2'b10);
      end else if (go_sw) begin
         m_ce = 0;
      end else begin
         m_age++;
         m_ce = (m_cur == 2'b10) || (m_age % div == div - 1);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_en) begin
            check("cycle_outputs", int'({udp_ce, speed_cur, busy, done, tmo}),
                  int'({m_ce, m_cur, m_busy, m_done, m_tmo}));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [1:0] ts;
      logic       idle;
      int         cyc;
      logic [1:0] exp_spd;
      int         exp_done;
      int         exp_tmo;
      int         exp_period;
   } vec_t;

   vec_t vecs[10];

   task automatic measure_period(input int exp, input string nm);
      int n;
      bit ok;
      ok = 0;
      n  = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (udp_ce) begin ok = 1; break; end
      end
      if (ok) begin
         for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (udp_ce) begin n = i; break; end
         end
      end
      check(nm, n, exp);
   endtask

   task automatic wait_busy(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy) begin ok = 1; break; end
      end
      check(nm, int'(ok), 1);
   endtask

   initial begin
      int nd, nt, hold, imode;

      vecs[0] = '{2'b01, 1'b1,  60, 2'b01, 1, 0, 10};
      vecs[1] = '{2'b00, 1'b1,   8, 2'b01, 0, 0, 0};
      vecs[2] = '{2'b01, 1'b1,  40, 2'b01, 0, 0, 0};
      vecs[3] = '{2'b00, 1'b0, 400, 2'b00, 1, 1, 100};
      vecs[4] = '{2'b11, 1'b1,  60, 2'b10, 1, 0, 1};
      vecs[5] = '{2'b10, 1'b1,  40, 2'b10, 0, 0, 0};
      vecs[6] = '{2'b11, 1'b1,  40, 2'b10, 0, 0, 0};
      vecs[7] = '{2'b01, 1'b1,  60, 2'b01, 1, 0, 0};
      vecs[8] = '{2'b11, 1'b1,  60, 2'b10, 1, 0, 0};
      vecs[9] = '{2'b00, 1'b1,  40, 2'b00, 1, 0, 100};

      rst_n = 1'b0;
      ts    = 2'b10;
      idle  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ce", int'(udp_ce), 0);
      check("reset_speed", int'(speed_cur), 2);
      check("reset_flags", int'({busy, done, tmo}), 0);
      rst_n = 1'b1;
      m_en  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("gig_ce_after_reset", int'(udp_ce), 1);
      end

      // Table-driven scenarios.
      foreach (vecs[k]) begin
         ts   = vecs[k].ts;
         idle = vecs[k].idle;
         nd   = 0;
         nt   = 0;
         for (int c = 0; c < vecs[k].cyc; c++) begin
            @(negedge clk);
            nd += int'(done);
            nt += int'(tmo);
         end
         check($sformatf("row%0d_speed", k), int'(speed_cur), int'(vecs[k].exp_spd));
         check($sformatf("row%0d_done_pulses", k), nd, vecs[k].exp_done);
         check($sformatf("row%0d_timeout_pulses", k), nt, vecs[k].exp_tmo);
         check($sformatf("row%0d_busy", k), int'(busy), 0);
         if (vecs[k].exp_period != 0) begin
            measure_period(vecs[k].exp_period, $sformatf("row%0d_ce_period", k));
         end
      end

      // Idle already high on drain entry: switch on the very next cycle.
      ts   = 2'b01;
      idle = 1'b1;
      wait_busy("idle_entry_busy_seen");
      @(negedge clk);
      check("idle_entry_switch_ce", int'(udp_ce), 0);
      check("idle_entry_switch_busy", int'(busy), 1);
      @(negedge clk);
      check("idle_entry_done", int'(done), 1);
      check("idle_entry_busy_clear", int'(busy), 0);
      check("idle_entry_speed", int'(speed_cur), 1);

      // Idle arrives on the very cycle the timeout would fire: no timeout pulse.
      ts   = 2'b00;
      idle = 1'b0;
      wait_busy("tie_busy_seen");
      repeat (TMO - 1) @(negedge clk);
      idle = 1'b1;
      @(negedge clk);
      check("tie_no_timeout", int'(tmo), 0);
      check("tie_switch_ce", int'(udp_ce), 0);
      @(negedge clk);
      check("tie_done", int'(done), 1);
      check("tie_speed", int'(speed_cur), 0);

      // Reset while draining: outputs return asynchronously, pending change lost.
      ts   = 2'b10;
      idle = 1'b0;
      wait_busy("rst_busy_seen");
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ce", int'(udp_ce), 0);
      check("rst_mid_speed", int'(speed_cur), 2);
      check("rst_mid_flags", int'({busy, done, tmo}), 0);
      @(negedge clk);
      idle  = 1'b1;
      rst_n = 1'b1;
      nd    = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         nd += int'(done);
      end
      check("rst_mid_no_done", nd, 0);
      check("rst_mid_speed_after", int'(speed_cur), 2);

      // Random stimulus; the per-cycle model comparison does the checking.
      for (int seg = 0; seg < 150; seg++) begin
         ts    = 2'($urandom_range(0, 3));
         hold  = int'($urandom_range(1, 45));
         imode = int'($urandom_range(0, 3));
         for (int c = 0; c < hold; c++) begin
            idle = (imode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      end
      idle = 1'b1;
      repeat (20) @(negedge clk);

      m_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
